isdu_ctrl: RTL

- Moore-style instruction sequencer for the LC-3 subset datapath.
- Sequences fetch/decode/execute and drives every load enable, gate, mux select and SRAM strobe.
- Owns the timing of the condition-code and branch-enable registers: LD_CC on result writes, LD_BEN in DECODE, and it consumes BEN in the BR states.
- Sits between top-level switch/button inputs and the datapath/memory interface.

---
 rtl/isdu_pkg.sv | 88 ++++++++
 rtl/isdu_ctrl_mem_wait_cnt.sv | 48 ++++
 rtl/isdu_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/isdu_pkg.sv
// -----------------------------------------------------------------------------
// isdu_pkg
// Shared definitions for the LC-3 subset instruction sequencer:
//   - state_t   : sequencer state encoding
//   - OP_*      : IR[15:12] opcode values the sequencer decodes
//   - PCMUX_*, ADDR2_*, ALUK_* : mux/ALU encodings shared with the datapath
//   - ctrl_t    : bundle of every control output, registered as one word
// -----------------------------------------------------------------------------
package isdu_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR0,
        S_BR1,
        S_JMP,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic       ADDR1_PC    = 1'b0;
    localparam logic       ADDR1_SR1   = 1'b1;

    localparam logic [1:0] ADDR2_ZERO   = 2'd0;
    localparam logic [1:0] ADDR2_SEXT6  = 2'd1;
    localparam logic [1:0] ADDR2_SEXT9  = 2'd2;
    localparam logic [1:0] ADDR2_SEXT11 = 2'd3;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // States that hold the SRAM strobe for MEM_WAIT cycles.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/isdu_ctrl_mem_wait_cnt.sv
// -----------------------------------------------------------------------------
// mem_wait_cnt
// 3-bit cycle counter used to stretch SRAM accesses to MEM_WAIT cycles.
// Ports:
//   Clk, Reset   : clock, synchronous active-low reset
//   clr_i        : restart the count at 0 (asserted on entry to a wait state)
//   en_i         : advance the count (asserted while staying in a wait state)
//   done_o       : current count is the last cycle of the access
//   last_nxt_o   : the count about to be loaded is the last cycle; lets the
//                  sequencer register LD_MDR so it lines up with done_o
// -----------------------------------------------------------------------------
module mem_wait_cnt #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o,
    output logic last_nxt_o
);

    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o     = (cnt_q == LAST);
    assign last_nxt_o = (cnt_d == LAST);

endmodule

// File: rtl/isdu_ctrl.sv
// -----------------------------------------------------------------------------
// isdu_ctrl
// Moore-style fetch/decode/execute sequencer for the LC-3 subset datapath.
// Every control output is registered: the output word for the state being
// entered is computed alongside the next state and loaded on the same edge,
// so outputs are glitch-free and always match the current state.
// Ports:
//   Clk, Reset          : clock, synchronous active-low reset
//   Run                 : leave HALTED (sampled only there)
//   Continue            : PAUSE handshake (high to leave PAUSE1, low to leave PAUSE2)
//   Opcode, IR_5, BEN   : IR[15:12], IR[5], registered branch enable
//   LD_*                : register load enables
//   Gate*               : one-hot bus drivers
//   PCMUX, ADDR1MUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX : datapath selects
//   Mem_OE, Mem_WE      : active-high SRAM strobes, held MEM_WAIT cycles
// -----------------------------------------------------------------------------
module isdu_ctrl
    import isdu_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;

    logic wait_clr;
    logic wait_en;
    logic wait_done;
    logic wait_last_nxt;

    mem_wait_cnt #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait (
        .Clk       (Clk),
        .Reset     (Reset),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .done_o    (wait_done),
        .last_nxt_o(wait_last_nxt)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: if (Run) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: if (wait_done) state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = S_BR0;
                    OP_JMP:   state_d = S_JMP;
                    OP_LDR:   state_d = S_LDR1;
                    OP_STR:   state_d = S_STR1;
                    OP_PAUSE: state_d = S_PAUSE1;
                    default:  state_d = S_FETCH1;   // unsupported opcode: NOP
                endcase
            end
            S_ADD, S_AND, S_NOT: state_d = S_FETCH1;
            S_BR0:    state_d = BEN ? S_BR1 : S_FETCH1;
            S_BR1:    state_d = S_FETCH1;
            S_JMP:    state_d = S_FETCH1;
            S_LDR1:   state_d = S_LDR2;
            S_LDR2:   if (wait_done) state_d = S_LDR3;
            S_LDR3:   state_d = S_FETCH1;
            S_STR1:   state_d = S_STR2;
            S_STR2:   state_d = S_STR3;
            S_STR3:   if (wait_done) state_d = S_FETCH1;
            S_PAUSE1: if (Continue) state_d = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_d = S_FETCH1;
            default:  state_d = S_HALTED;
        endcase
    end

    // Wait counter restarts on every entry to a wait state and counts while
    // the sequencer stays there; no wait state can follow itself directly.
    assign wait_clr = is_wait_state(state_d) && (state_d != state_q);
    assign wait_en  = is_wait_state(state_q) && (state_d == state_q);

    // Output word for the state being entered
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH1: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.ld_mar  = 1'b1;
                ctrl_d.pcmux   = PCMUX_INC;
                ctrl_d.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                ctrl_d.mem_oe = 1'b1;
                ctrl_d.ld_mdr = wait_last_nxt;   // capture data on the final read cycle
            end
            S_FETCH3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_ir    = 1'b1;
            end
            S_DECODE: ctrl_d.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
                if (state_d == S_ADD) begin
                    ctrl_d.aluk   = ALUK_ADD;
                    ctrl_d.sr2mux = IR_5;
                end else if (state_d == S_AND) begin
                    ctrl_d.aluk   = ALUK_AND;
                    ctrl_d.sr2mux = IR_5;
                end else begin
                    ctrl_d.aluk   = ALUK_NOT;
                end
            end
            S_BR1: begin
                ctrl_d.addr1mux = ADDR1_PC;
                ctrl_d.addr2mux = ADDR2_SEXT9;
                ctrl_d.pcmux    = PCMUX_ADDER;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_d.addr1mux = ADDR1_SR1;
                ctrl_d.addr2mux = ADDR2_ZERO;
                ctrl_d.pcmux    = PCMUX_ADDER;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl_d.addr1mux    = ADDR1_SR1;
                ctrl_d.addr2mux    = ADDR2_SEXT6;
                ctrl_d.gate_marmux = 1'b1;
                ctrl_d.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_STR2: begin
                ctrl_d.sr1mux   = 1'b1;
                ctrl_d.aluk     = ALUK_PASSA;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_mdr   = 1'b1;
            end
            S_STR3: ctrl_d.mem_we = 1'b1;
            // LED latch pulses only on the cycle PAUSE1 is entered
            S_PAUSE1: ctrl_d.ld_led = (state_q != S_PAUSE1);
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_HALTED;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;

endmodule
